// File: rtl/chess_clock_pkg.sv
// Shared definitions for the chess clock: turn controller state codes and player IDs.
package chess_clock_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = 3'd0,
    S_RUN_A   = 3'd1,
    S_RUN_B   = 3'd2,
    S_PAUSED  = 3'd3,
    S_FLAGGED = 3'd4
  } state_t;

  typedef enum logic {
    PLAYER_A = 1'b0,
    PLAYER_B = 1'b1
  } player_t;

endpackage

// File: rtl/turn_controller.sv
// Chess clock turn controller: one FSM deciding whose timer runs, plus TICK gating.
// Define TURN_CONTROLLER_INCREMENT_EN to pulse ADD_A/ADD_B on each completed turn.
module turn_controller
  import chess_clock_pkg::*;
#(
  parameter bit START_PLAYER = 1'b0
) (
  input  logic               CLK,
  input  logic               CLR_N,
  input  logic               START,
  input  logic               PAUSE,
  input  logic               BTN_A,
  input  logic               BTN_B,
  input  logic               TICK,
  input  logic               ZERO_A,
  input  logic               ZERO_B,
  output logic               LOAD_TIMERS,
  output logic               CE_A,
  output logic               CE_B,
  output logic               IMPULSE_A,
  output logic               IMPULSE_B,
  output logic               ADD_A,
  output logic               ADD_B,
  output logic               ACTIVE,
  output logic               FLAG_A,
  output logic               FLAG_B,
  output logic [STATE_W-1:0] STATE
);

`ifdef TURN_CONTROLLER_INCREMENT_EN
  localparam bit INCREMENT_EN = 1'b1;
`else
  localparam bit INCREMENT_EN = 1'b0;
`endif

  state_t state;
  logic   active;
  logic   ce_a, ce_b;
  logic   flag_a, flag_b;
  logic   add_a, add_b;

  // Only a lone button press ends a turn; both at once is treated as noise.
  logic press_a, press_b;
  assign press_a = BTN_A & ~BTN_B;
  assign press_b = BTN_B & ~BTN_A;

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state  <= S_IDLE;
      active <= START_PLAYER;
      ce_a   <= 1'b0;
      ce_b   <= 1'b0;
      flag_a <= 1'b0;
      flag_b <= 1'b0;
      add_a  <= 1'b0;
      add_b  <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults first; any branch below may override them, giving one-cycle pulses.
      add_a <= 1'b0;
      add_b <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            active <= START_PLAYER;
            ce_a   <= (START_PLAYER == PLAYER_A);
            ce_b   <= (START_PLAYER == PLAYER_B);
            state  <= (START_PLAYER == PLAYER_B) ? S_RUN_B : S_RUN_A;
          end
        end
        S_RUN_A: begin
          // Running out of time outranks any move or pause arriving with it.
          if (ZERO_A) begin
            state  <= S_FLAGGED;
            flag_a <= 1'b1;
            ce_a   <= 1'b0;
          end else if (PAUSE) begin
            state <= S_PAUSED;
            ce_a  <= 1'b0;
          end else if (press_a) begin
            state  <= S_RUN_B;
            active <= PLAYER_B;
            ce_a   <= 1'b0;
            ce_b   <= 1'b1;
            add_a  <= INCREMENT_EN;
          end
        end
        S_RUN_B: begin
          if (ZERO_B) begin
            state  <= S_FLAGGED;
            flag_b <= 1'b1;
            ce_b   <= 1'b0;
          end else if (PAUSE) begin
            state <= S_PAUSED;
            ce_b  <= 1'b0;
          end else if (press_b) begin
            state  <= S_RUN_A;
            active <= PLAYER_A;
            ce_b   <= 1'b0;
            ce_a   <= 1'b1;
            add_b  <= INCREMENT_EN;
          end
        end
        S_PAUSED: begin
          // ACTIVE still names the paused player, so it doubles as the resume target.
          if (PAUSE) begin
            state <= active ? S_RUN_B : S_RUN_A;
            ce_a  <= ~active;
            ce_b  <= active;
          end
        end
        S_FLAGGED: begin
          if (START) begin
            state  <= S_IDLE;
            active <= START_PLAYER;
            flag_a <= 1'b0;
            flag_b <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Gating on the registered state hands a TICK in a handover cycle to the player being left.
  assign IMPULSE_A   = TICK & (state == S_RUN_A);
  assign IMPULSE_B   = TICK & (state == S_RUN_B);
  assign LOAD_TIMERS = (state == S_IDLE);
  assign CE_A        = ce_a;
  assign CE_B        = ce_b;
  assign ADD_A       = add_a;
  assign ADD_B       = add_b;
  assign ACTIVE      = active;
  assign FLAG_A      = flag_a;
  assign FLAG_B      = flag_b;
  assign STATE       = state;

endmodule
